// File: rtl/tx_sched_pkg.sv
// Shared constants for the TX DRAM read scheduler: FSM state encoding,
// the AXI 4 KB page size and the AXI arlen width.
package tx_sched_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CALC   = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam int AXI_4KB = 4096;
  localparam int ARLEN_W = 8;

endpackage

// File: rtl/tx_burst_len_calc.sv
// Combinational burst sizing: min(MAX_BURST, remaining beats, beats left before
// the next 4 KB page boundary). Result is a beat count (1..256), not arlen.
module tx_burst_len_calc
  import tx_sched_pkg::*;
#(
  parameter int BEAT_BYTES = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic [11:0]      addr_lo,
  input  logic [23:0]      remain,
  output logic [ARLEN_W:0] len
);

  logic [12:0] bytes_to_4kb;
  logic [23:0] beats_to_4kb;
  logic [23:0] len_min;

  always_comb begin
    bytes_to_4kb = 13'(AXI_4KB) - {1'b0, addr_lo};
    beats_to_4kb = 24'(bytes_to_4kb / 13'(BEAT_BYTES));
    len_min      = 24'(MAX_BURST);
    if (remain < len_min) len_min = remain;
    if (beats_to_4kb < len_min) len_min = beats_to_4kb;
    len = len_min[ARLEN_W:0];
  end

endmodule

// File: rtl/tx_dram_read_scheduler.sv
// Issues AXI AR bursts over a DRAM region, throttled by TX FIFO credit
// (fill count + beats in flight), and reports busy/done/aborted to the host.
module tx_dram_read_scheduler
  import tx_sched_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 32,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 128,
  parameter int CNT_W      = 8,
  parameter int MARGIN     = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [23:0]       num_beats,
  input  logic [CNT_W-1:0]  fifo_wr_cnt,
  input  logic              r_beat,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic              arvalid,
  input  logic              arready,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [2:0]        dbg_state,
  output logic [CNT_W-1:0]  dbg_outstanding
);

  // Wide enough that fill + outstanding + len can never wrap.
  localparam int CRED_W = ((CNT_W > ARLEN_W) ? CNT_W : ARLEN_W) + 3;
  localparam logic [CRED_W-1:0] CREDIT_LIMIT = CRED_W'(FIFO_DEPTH - MARGIN);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [23:0]       remain;
  logic [CNT_W-1:0]  outstanding;
  logic [ARLEN_W:0]  len_q;
  logic              abort_pend;

  logic [ARLEN_W:0]  len;
  logic [ARLEN_W:0]  len_m1;
  logic [CRED_W-1:0] credit_sum;
  logic              credit_ok;
  logic              ar_hs;
  logic              out_dec;
  logic [CNT_W-1:0]  out_inc;
  logic [23:0]       remain_next;
  logic [ADDR_W-1:0] addr_next;

  tx_burst_len_calc #(
    .BEAT_BYTES (BEAT_BYTES),
    .MAX_BURST  (MAX_BURST)
  ) u_len_calc (
    .addr_lo (addr[11:0]),
    .remain  (remain),
    .len     (len)
  );

  always_comb begin
    len_m1      = len - 1'b1;
    credit_sum  = CRED_W'(fifo_wr_cnt) + CRED_W'(outstanding) + CRED_W'(len);
    credit_ok   = (credit_sum <= CREDIT_LIMIT);
    ar_hs       = arvalid && arready;
    out_inc     = ar_hs ? CNT_W'(len_q) : '0;
    // A stray beat with nothing in flight must not wrap the counter.
    out_dec     = r_beat && (outstanding != '0);
    remain_next = remain - 24'(len_q);
    addr_next   = addr + ADDR_W'(len_q) * ADDR_W'(BEAT_BYTES);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      addr        <= '0;
      remain      <= '0;
      outstanding <= '0;
      len_q       <= '0;
      abort_pend  <= 1'b0;
      araddr      <= '0;
      arlen       <= '0;
      arvalid     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done        <= 1'b0;
      outstanding <= outstanding + out_inc - CNT_W'(out_dec);
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr       <= base_addr;
            remain     <= num_beats;
            busy       <= 1'b1;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            state      <= (num_beats != '0) ? ST_CALC : ST_FINISH;
          end
        end
        ST_CALC: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_DRAIN;
          end else if (credit_ok) begin
            araddr  <= addr;
            arlen   <= len_m1[7:0];
            len_q   <= len;
            arvalid <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // AR must stay up until accepted; a pulsed abort is remembered.
          if (abort) abort_pend <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            addr    <= addr_next;
            remain  <= remain_next;
            if (abort || abort_pend) begin
              aborted <= 1'b1;
              state   <= ST_DRAIN;
            end else if (remain_next != '0) begin
              state <= ST_CALC;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0) state <= ST_FINISH;
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state       = state;
  assign dbg_outstanding = outstanding;

  a_rbeat_underflow: assert property (@(posedge clk) disable iff (!rstn)
    r_beat |-> (outstanding != '0));

endmodule

// File: tb/tb_tx_dram_read_scheduler.sv
// Bench for tx_dram_read_scheduler: a burst-plan model, an AR monitor with
// an expected-burst queue, an R-beat responder and an outstanding-beat model.
module tb_tx_dram_read_scheduler;
  import tx_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] base_addr = '0;
  logic [23:0] num_beats = '0;
  logic [7:0]  fifo_wr_cnt = '0;
  logic        r_beat = 1'b0;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic        busy, done, aborted;
  logic [2:0]  dbg_state;
  logic [7:0]  dbg_outstanding;

  // arready source: 0 = always ready, 1 = random, 2 = manual
  int   ar_mode = 0;
  logic ar_manual = 1'b0;
  logic rnd_bit = 1'b1;
  logic resp_en = 1'b1;
  logic rb_manual = 1'b0;
  assign arready = (ar_mode == 0) ? 1'b1 : (ar_mode == 1) ? rnd_bit : ar_manual;
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  tx_dram_read_scheduler dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .abort           (abort),
    .base_addr       (base_addr),
    .num_beats       (num_beats),
    .fifo_wr_cnt     (fifo_wr_cnt),
    .r_beat          (r_beat),
    .araddr          (araddr),
    .arlen           (arlen),
    .arvalid         (arvalid),
    .arready         (arready),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .dbg_state       (dbg_state),
    .dbg_outstanding (dbg_outstanding)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [39:0] exp_q[$];     // {araddr, arlen}
  int beat_q[$];             // cycle at which each owed R beat may return
  int model_out = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;

  // Burst plan from the region rules: never past MAX_BURST, the region end, or a 4 KB page.
  function automatic void plan(input logic [31:0] base, input int n);
    logic [31:0] a;
    int rem, len, b4k;
    a = base;
    rem = n;
    while (rem > 0) begin
      b4k = (4096 - int'(a % 32'd4096)) / 32;
      len = 16;
      if (rem < len) len = rem;
      if (b4k < len) len = b4k;
      exp_q.push_back({a, 8'(len - 1)});
      a = a + 32'(len * 32);
      rem = rem - len;
    end
  endfunction

  // ---------------- monitor + R responder ----------------
  always @(negedge clk) begin
    logic [39:0] e;
    cyc++;
    if (!rstn) begin
      r_beat = 1'b0;
      model_out = 0;
      beat_q.delete();
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (dbg_outstanding !== 8'(model_out)) begin
        errors++;
        $display("FAIL outstanding cyc=%0d got=%0d exp=%0d", cyc, dbg_outstanding, model_out);
      end
      if (prev_stall) begin
        checks++;
        if (arvalid !== 1'b1 || araddr !== prev_addr || arlen !== prev_len) begin
          errors++;
          $display("FAIL ar_stable cyc=%0d got v=%0b a=%h l=%0d exp v=1 a=%h l=%0d",
                   cyc, arvalid, araddr, arlen, prev_addr, prev_len);
        end
      end
      prev_stall = arvalid && !arready;
      prev_addr = araddr;
      prev_len = arlen;
      if (done === 1'b1) done_cnt++;
      if (arvalid && arready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ar_unexpected cyc=%0d got a=%h l=%0d exp none", cyc, araddr, arlen);
        end else begin
          e = exp_q.pop_front();
          if ({araddr, arlen} !== e) begin
            errors++;
            $display("FAIL ar_burst cyc=%0d got a=%h l=%0d exp a=%h l=%0d",
                     cyc, araddr, arlen, e[39:8], e[7:0]);
          end
        end
        checks++;
        if (int'(fifo_wr_cnt) + model_out + int'(arlen) + 1 > 126) begin
          errors++;
          $display("FAIL ar_credit cyc=%0d got fill=%0d out=%0d len=%0d exp sum<=126",
                   cyc, fifo_wr_cnt, model_out, int'(arlen) + 1);
        end
        model_out += int'(arlen) + 1;
        for (int i = 0; i <= int'(arlen); i++) beat_q.push_back(cyc + 4);
      end
      if (rb_manual) begin
        r_beat = 1'b1;
        if (beat_q.size() > 0) void'(beat_q.pop_front());
      end else if (resp_en && beat_q.size() > 0 && beat_q[0] <= cyc) begin
        r_beat = 1'b1;
        void'(beat_q.pop_front());
      end else begin
        r_beat = 1'b0;
      end
      if (r_beat) model_out--;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [31:0] base, input int n, output int d0);
    d0 = done_cnt;
    base_addr = base;
    num_beats = 24'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_arvalid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (arvalid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_hs(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (arvalid === 1'b1 && arready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_job(input string name, input logic exp_ab, input int d0);
    bit ok;
    wait_done(4000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout got no done exp done", name);
    end else begin
      checks++;
      if (aborted !== exp_ab) begin
        errors++;
        $display("FAIL %s_aborted got %0b exp %0b", name, aborted, exp_ab);
      end
      checks++;
      if (dbg_outstanding !== 8'd0) begin
        errors++;
        $display("FAIL %s_out_at_done got %0d exp 0", name, dbg_outstanding);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_bursts_left got %0d exp 0", name, exp_q.size());
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s_done_count got %0d exp 1", name, done_cnt - d0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_after got %0b exp 0", name, busy);
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (arvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 ||
        araddr !== 32'd0 || arlen !== 8'd0 || dbg_outstanding !== 8'd0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_values got v=%0b b=%0b d=%0b ab=%0b a=%h l=%0d o=%0d s=%0d exp all 0",
               arvalid, busy, done, aborted, araddr, arlen, dbg_outstanding, dbg_state);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int d0;
    ar_mode = 0;
    abort = 1'b1;   // abort while idle must be ignored
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL idle_abort got b=%0b s=%0d exp b=0 s=IDLE", busy, dbg_state);
    end
    plan(32'h0, 40);
    start_job(32'h0, 40, d0);
    finish_job("basic", 1'b0, d0);
  endtask

  task automatic test_4kb();
    int d0;
    plan(32'hF80, 10);
    start_job(32'hF80, 10, d0);
    finish_job("boundary_4kb", 1'b0, d0);
  endtask

  task automatic test_credit();
    int d0;
    bit ok;
    fifo_wr_cnt = 8'd120;
    plan(32'h0, 16);
    start_job(32'h0, 16, d0);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (arvalid !== 1'b0 || dbg_state !== ST_CALC) begin
      errors++;
      $display("FAIL credit_stall got v=%0b s=%0d exp v=0 s=CALC", arvalid, dbg_state);
    end
    fifo_wr_cnt = 8'd100;
    wait_arvalid(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL credit_release got no arvalid exp arvalid within 1 eval");
    end
    @(posedge clk); #1;
    finish_job("credit", 1'b0, d0);
    fifo_wr_cnt = 8'd0;
  endtask

  task automatic test_backpressure();
    int d0;
    bit ok;
    ar_mode = 2;
    ar_manual = 1'b0;
    plan(32'h100, 16);
    start_job(32'h100, 16, d0);
    wait_arvalid(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_arvalid got 0 exp 1");
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (dbg_outstanding !== 8'd0 || arvalid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold got o=%0d v=%0b exp o=0 v=1", dbg_outstanding, arvalid);
    end
    ar_manual = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dbg_outstanding !== 8'd16 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single_hs got o=%0d v=%0b exp o=16 v=0", dbg_outstanding, arvalid);
    end
    ar_mode = 0;
    finish_job("backpressure", 1'b0, d0);
  endtask

  task automatic test_abort_issue();
    int d0;
    bit ok;
    ar_mode = 2;
    ar_manual = 1'b1;
    plan(32'h0, 64);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    start_job(32'h0, 64, d0);
    wait_hs(20, ok);
    @(posedge clk); #1;
    ar_manual = 1'b0;
    wait_arvalid(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_second_issue got no arvalid exp arvalid");
    end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (arvalid !== 1'b1) begin
      errors++;
      $display("FAIL abort_hold_ar got %0b exp 1", arvalid);
    end
    ar_manual = 1'b1;
    finish_job("abort_issue", 1'b1, d0);
    ar_mode = 0;
  endtask

  task automatic test_abort_calc();
    int d0;
    fifo_wr_cnt = 8'd120;
    start_job(32'h0, 16, d0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    finish_job("abort_calc", 1'b1, d0);
    fifo_wr_cnt = 8'd0;
  endtask

  task automatic test_zero();
    logic seen_v;
    start = 1'b1;
    num_beats = 24'd0;
    base_addr = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    seen_v = 1'b0;
    @(negedge clk);
    seen_v |= arvalid;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_cycle1 got d=%0b b=%0b exp d=0 b=1", done, busy);
    end
    @(negedge clk);
    seen_v |= arvalid;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got d=%0b b=%0b exp d=1 b=0", done, busy);
    end
    @(negedge clk);
    seen_v |= arvalid;
    checks++;
    if (done !== 1'b0 || seen_v !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse got d=%0b v=%0b exp d=0 v=0", done, seen_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_simul();
    int d0;
    bit ok;
    ar_mode = 2;
    ar_manual = 1'b1;
    resp_en = 1'b0;
    plan(32'h0, 32);
    start_job(32'h0, 32, d0);
    wait_hs(20, ok);
    @(posedge clk); #1;
    ar_manual = 1'b0;
    wait_arvalid(10, ok);
    @(posedge clk); #1;
    ar_manual = 1'b1;
    rb_manual = 1'b1;
    @(posedge clk); #1;
    ar_manual = 1'b0;
    rb_manual = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_outstanding !== 8'd31) begin
      errors++;
      $display("FAIL simul_hs_beat got %0d exp 31", dbg_outstanding);
    end
    @(posedge clk); #1;
    resp_en = 1'b1;
    ar_mode = 0;
    finish_job("simul", 1'b0, d0);
  endtask

  task automatic test_rst_mid();
    int d0;
    bit ok;
    ar_mode = 2;
    ar_manual = 1'b1;
    resp_en = 1'b0;
    plan(32'h0, 64);
    start_job(32'h0, 64, d0);
    wait_hs(20, ok);
    @(posedge clk); #1;
    ar_manual = 1'b0;
    wait_arvalid(10, ok);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (arvalid !== 1'b0 || busy !== 1'b0 || dbg_outstanding !== 8'd0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_mid got v=%0b b=%0b o=%0d s=%0d exp all 0",
               arvalid, busy, dbg_outstanding, dbg_state);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    resp_en = 1'b1;
    ar_mode = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int d0, n;
    logic [31:0] base;
    ar_mode = 1;
    for (int j = 0; j < 8; j++) begin
      base = 32'($urandom_range(0, 'h7FFF)) << 5;
      n = $urandom_range(0, 70);
      fifo_wr_cnt = 8'($urandom_range(0, 110));
      plan(base, n);
      start_job(base, n, d0);
      finish_job("random", 1'b0, d0);
    end
    fifo_wr_cnt = 8'd0;
    ar_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_4kb();
    test_credit();
    test_backpressure();
    test_abort_issue();
    test_abort_calc();
    test_zero();
    test_simul();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
